mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit owning the HI/LO architectural registers; successor to the single-cycle HI/LO handling in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute, runs multi-cycle, and asserts busy so the pipeline stalls any dependent MFHI/MFLO or new mul/div.
- HI/LO are read combinationally by execute for MFHI/MFLO.

---
 rtl/mips_muldiv_unit_if.sv | 17 +
 rtl/mips_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// Execute-stage <-> mul/div unit bus: request, abort, status and the HI/LO read-out.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2^MUL_STEP shift-add multiply,
// restoring divide, sign fix-up in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic                clock,
  input  logic                reset,
  mips_muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Operand conditioning at accept time
  logic             is_muldiv;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign is_muldiv = ~bus.op[2];
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign abs_a     = a_neg ? -bus.a : bus.a;
  assign abs_b     = b_neg ? -bus.b : bus.b;

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle
  logic [MUL_STEP-1:0]       digit;
  logic [WIDTH+MUL_STEP-1:0] pp;
  logic [WIDTH+MUL_STEP-1:0] mul_sum;
  logic [2*WIDTH-1:0]        mul_next;

  assign digit    = acc[MUL_STEP-1:0];
  assign pp       = {{MUL_STEP{1'b0}}, opnd} * {{WIDTH{1'b0}}, digit};
  assign mul_sum  = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
  assign mul_next = {mul_sum, acc[WIDTH-1:MUL_STEP]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}, shifted left
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  assign div_r    = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_r >= {1'b0, opnd};
  assign div_sub  = div_r[WIDTH-1:0] - opnd;
  assign div_next = {div_ge ? div_sub : div_r[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

  // Sign fix-up; a zero divisor leaves |a| as remainder, so re-signing it restores a
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = div_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.op == OP_MTHI) begin
                hi_q <= bus.a;
              end else if (bus.op == OP_MTLO) begin
                lo_q <= bus.a;
              end else if (is_muldiv) begin
                is_div   <= bus.op[1];
                opnd     <= bus.op[1] ? abs_b : abs_a;
                acc      <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
                div_zero <= bus.op[1] & (bus.b == '0);
                cnt      <= '0;
                state    <= S_CALC;
              end
            end
          end
          S_CALC: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == (is_div ? DIV_LAST : MUL_LAST)) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Two units (MUL_STEP 1 and 4) share one stimulus stream; each is checked every cycle
// against an arithmetic model, with literal spot checks on the documented cases.
module tb_mips_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  bit          cmp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mips_muldiv_unit_if #(.WIDTH(32)) bus1 ();
  mips_muldiv_unit_if #(.WIDTH(32)) bus4 ();

  assign bus1.start = start;  assign bus4.start = start;
  assign bus1.op    = op;     assign bus4.op    = op;
  assign bus1.a     = a;      assign bus4.a     = a;
  assign bus1.b     = b;      assign bus4.b     = b;
  assign bus1.flush = flush;  assign bus4.flush = flush;

  mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u1 (.clock(clock), .reset(reset), .bus(bus1));
  mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u4 (.clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;

  function automatic logic dut_busy(input int k);
    return (k == 0) ? bus1.busy : bus4.busy;
  endfunction
  function automatic logic dut_done(input int k);
    return (k == 0) ? bus1.done : bus4.done;
  endfunction
  function automatic logic [31:0] dut_hi(input int k);
    return (k == 0) ? bus1.hi : bus4.hi;
  endfunction
  function automatic logic [31:0] dut_lo(input int k);
    return (k == 0) ? bus1.lo : bus4.lo;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sp;
    int     sq;
    int     sr;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return 64'(sp);
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  int          step_of [2] = '{1, 4};
  bit          m_busy  [2] = '{0, 0};
  bit          m_done  [2] = '{0, 0};
  int          m_left  [2] = '{0, 0};
  logic [31:0] m_hi    [2] = '{32'd0, 32'd0};
  logic [31:0] m_lo    [2] = '{32'd0, 32'd0};
  logic [63:0] m_res   [2] = '{64'd0, 64'd0};

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0;
        m_hi[k] = '0; m_lo[k] = '0;
      end else begin
        m_done[k] = 0;
        if (flush) begin
          m_busy[k] = 0;
        end else if (m_busy[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_hi[k]   = m_res[k][63:32];
            m_lo[k]   = m_res[k][31:0];
          end
        end else if (start) begin
          if (op == 3'd4) m_hi[k] = a;
          else if (op == 3'd5) m_lo[k] = a;
          else if (op < 3'd4) begin
            m_res[k]  = ref_result(op, a, b);
            m_busy[k] = 1;
            m_left[k] = (op >= 3'd2) ? 33 : (32 / step_of[k] + 1);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_busy[%0d]", k), {31'd0, dut_busy(k)}, {31'd0, m_busy[k]});
        chk($sformatf("cyc_done[%0d]", k), {31'd0, dut_done(k)}, {31'd0, m_done[k]});
        chk($sformatf("cyc_hi[%0d]", k), dut_hi(k), m_hi[k]);
        chk($sformatf("cyc_lo[%0d]", k), dut_lo(k), m_lo[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns at the falling edge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic measure(input int k, output int lat, output int bc);
    lat = 0; bc = 0;
    while (!dut_done(k) && lat < 200) begin
      if (dut_busy(k)) bc++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus1.busy || bus4.busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", {30'd0, bus1.busy, bus4.busy}, 32'd0);
    @(negedge clock);
  endtask

  task automatic chk_both(input string name, input logic [31:0] eh, input logic [31:0] el);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_hi[%0d]", name, k), dut_hi(k), eh);
      chk($sformatf("%s_lo[%0d]", name, k), dut_lo(k), el);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int pulses;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_busy", {31'd0, bus1.busy}, 32'd0);
    chk("rst_done", {31'd0, bus1.done}, 32'd0);
    chk_both("rst", 32'd0, 32'd0);

    issue(3'd0, 32'hFFFFFFFD, 32'h00000007);
    measure(0, lat, bc);
    chk("mult_latency", lat, 33);
    chk("mult_busy_cycles", bc, 33);
    wait_idle();
    chk_both("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    measure(1, lat, bc);
    chk("multu_s4_latency", lat, 9);
    chk("multu_s4_busy_cycles", bc, 9);
    wait_idle();
    chk_both("multu", 32'hFFFFFFFE, 32'h00000001);

    issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
    measure(1, lat, bc);
    chk("div_latency", lat, 33);
    wait_idle();
    chk_both("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk_both("div_ovf", 32'h00000000, 32'h80000000);

    issue(3'd0, 32'h80000000, 32'h80000000);
    wait_idle();
    chk_both("mult_min", 32'h40000000, 32'h00000000);

    issue(3'd2, 32'hFFFFFFF9, 32'h00000000);
    wait_idle();
    chk_both("div_zero_s", 32'hFFFFFFF9, 32'hFFFFFFFF);

    issue(3'd3, 32'h00000064, 32'h00000000);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    chk_both("divu_zero", 32'h00000064, 32'hFFFFFFFF);

    issue(3'd4, 32'h12345678, 32'h0);
    chk("mthi_busy", {31'd0, bus1.busy}, 32'd0);
    chk_both("mthi", 32'h12345678, 32'hFFFFFFFF);

    issue(3'd0, 32'd2, 32'd3);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy", {31'd0, bus1.busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.done) pulses++;
      @(negedge clock);
    end
    chk("flush_done_pulses", pulses, 0);
    chk("flush_hi", bus1.hi, 32'h12345678);
    chk("flush_lo", bus1.lo, 32'hFFFFFFFF);
    chk("flush_s4_lo", bus4.lo, 32'h00000006);

    start = 1'b1; op = 3'd5; a = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    chk("flush_mtlo_lo", bus1.lo, 32'hFFFFFFFF);

    issue(3'd7, 32'hAAAA5555, 32'h1);
    chk("nop_busy", {31'd0, bus1.busy}, 32'd0);
    chk("nop_hi", bus1.hi, 32'h12345678);

    issue(3'd2, 32'd100, 32'd7);
    repeat (16) @(negedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus1.busy, bus4.busy}, 32'd0);
    chk("arst_done", {31'd0, bus1.done, bus4.done}, 32'd0);
    chk_both("arst", 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue(3'd0, 32'd5, 32'd5);
    wait_idle();
    chk_both("mult_after_rst", 32'd0, 32'h00000019);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
